cp_remove: RTL

Receive-side counterpart of the transmit cyclic-prefix inserter in the OFDM modem. It accepts a continuous stream of OFDM symbols, each made of N_CP prefix samples followed by N_FFT body samples and marked by in_sop on the first prefix sample. It discards the prefix and forwards the N_FFT body samples to the FFT input with fresh sop/eop framing. The block sits between the receive synchronizer and the FFT. It is streaming only and has no RAM.

---
 rtl/ofdm_pkg.sv | 11 +
 rtl/cp_remove.sv | 117 +++++++++++
 2 files changed

// File: rtl/ofdm_pkg.sv
// Constants shared by the OFDM cyclic-prefix inserter (TX) and remover (RX).
package ofdm_pkg;

  localparam int N_FFT_DEF = 1024;
  localparam int N_CP_DEF  = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SKIP = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;

endpackage

// File: rtl/cp_remove.sv
// Receive-side cyclic-prefix remover: drops N_CP prefix samples per symbol and
// forwards the N_FFT body samples with fresh sop/eop framing, one clock later.
module cp_remove
  import ofdm_pkg::*;
#(
  parameter int N_FFT = N_FFT_DEF,
  parameter int N_CP  = N_CP_DEF,
  parameter int W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  output logic signed [W-1:0] out_i,
  output logic signed [W-1:0] out_q,
  output logic                out_valid,
  output logic                sop_out,
  output logic                eop_out,
  output logic                err_resync
);

  localparam int CW = $clog2(N_CP + N_FFT);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [W-1:0] dataI_q, dataI_d;
  logic signed [W-1:0] dataQ_q, dataQ_d;
  logic                valid_q, valid_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic                err_q, err_d;

  // A sop on any accepted sample always restarts the symbol; outside IDLE it is a resync.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dataI_d = dataI_q;
    dataQ_d = dataQ_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    if (en && in_valid) begin
      if (in_sop) begin
        err_d = (state_q != ST_IDLE);
        if (N_CP == 1) begin
          state_d = ST_PASS;
          cnt_d   = '0;
        end else begin
          state_d = ST_SKIP;
          cnt_d   = CW'(1);
        end
      end else begin
        case (state_q)
          ST_SKIP: begin
            if (cnt_q == CW'(N_CP - 1)) begin
              state_d = ST_PASS;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          ST_PASS: begin
            dataI_d = in_i;
            dataQ_d = in_q;
            valid_d = 1'b1;
            sop_d   = (cnt_q == '0);
            eop_d   = (cnt_q == CW'(N_FFT - 1));
            if (cnt_q == CW'(N_FFT - 1)) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dataI_q <= '0;
      dataQ_q <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dataI_q <= dataI_d;
      dataQ_q <= dataQ_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

  assign out_i      = dataI_q;
  assign out_q      = dataQ_q;
  assign out_valid  = valid_q;
  assign sop_out    = sop_q;
  assign eop_out    = eop_q;
  assign err_resync = err_q;

endmodule
